iomem_ctrl: RTL and testbench

Peripheral-bus controller between the picosoc `iomem_*` port and up to 16 memory-mapped peripherals. It decodes the address page to a one-hot peripheral select, registers the request, and sequences the handshake. It returns the selected peripheral's read data to the CPU. A timeout watchdog and an unmapped-address responder guarantee the CPU never stalls, and the first faulting address is logged for firmware.

---
 rtl/iomem_ctrl.sv | 124 ++++++++++++
 tb/tb_iomem_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/iomem_ctrl.sv
// Picosoc iomem bus controller: page decode to one-hot peripheral select,
// handshake sequencing with timeout watchdog, unmapped responder and error log.
module iomem_ctrl #(
    parameter logic [7:0]  BASE_PAGE = 8'h03,
    parameter int unsigned NUM_SLOTS = 4,
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    iomem_valid,
    output logic                    iomem_ready,
    input  logic [3:0]              iomem_wstrb,
    input  logic [31:0]             iomem_addr,
    input  logic [31:0]             iomem_wdata,
    output logic [31:0]             iomem_rdata,
    output logic [NUM_SLOTS-1:0]    per_sel,
    output logic [3:0]              per_wstrb,
    output logic [23:0]             per_addr,
    output logic [31:0]             per_wdata,
    input  logic [NUM_SLOTS-1:0]    per_ready,
    input  logic [32*NUM_SLOTS-1:0] per_rdata,
    output logic                    err_flag,
    output logic [31:0]             err_addr,
    input  logic                    err_clear
);

    localparam logic [8:0]           SLOTS9  = 9'(NUM_SLOTS);
    localparam logic [15:0]          TLAST   = 16'(TIMEOUT - 1);
    localparam logic [NUM_SLOTS-1:0] SEL_LSB = NUM_SLOTS'(1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state;
    logic [15:0] timer;
    logic [7:0]  req_page;
    logic [8:0]  slot_off;
    logic        mapped;
    logic        sel_ready;
    logic        log_err;
    logic [31:0] sel_rdata;
    logic [31:0] log_addr;

    always_comb begin
        // 9-bit difference: bit 8 set means the page lies below BASE_PAGE
        slot_off  = {1'b0, iomem_addr[31:24]} - {1'b0, BASE_PAGE};
        mapped    = !slot_off[8] && (slot_off < SLOTS9);
        sel_ready = |(per_ready & per_sel);
        sel_rdata = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (per_sel[i]) sel_rdata = per_rdata[32*i +: 32];
        end
        log_err  = 1'b0;
        log_addr = iomem_addr;
        case (state)
            IDLE:    if (iomem_valid && !mapped) log_err = 1'b1;
            ACCESS:  if (!sel_ready && timer == TLAST) begin
                         log_err  = 1'b1;
                         log_addr = {req_page, per_addr};
                     end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            timer       <= '0;
            req_page    <= '0;
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
            per_sel     <= '0;
            per_wstrb   <= '0;
            per_addr    <= '0;
            per_wdata   <= '0;
            err_flag    <= 1'b0;
            err_addr    <= '0;
        end else begin
            iomem_ready <= 1'b0;
            case (state)
                IDLE: if (iomem_valid) begin
                    per_addr  <= iomem_addr[23:0];
                    per_wstrb <= iomem_wstrb;
                    per_wdata <= iomem_wdata;
                    req_page  <= iomem_addr[31:24];
                    timer     <= '0;
                    if (mapped) begin
                        per_sel <= SEL_LSB << slot_off[7:0];
                        state   <= ACCESS;
                    end else begin
                        iomem_rdata <= ERR_DATA;
                        iomem_ready <= 1'b1;
                        state       <= RESP;
                    end
                end
                ACCESS: begin
                    if (sel_ready) begin
                        iomem_rdata <= sel_rdata;
                        per_sel     <= '0;
                        iomem_ready <= 1'b1;
                        state       <= RESP;
                    end else if (timer == TLAST) begin
                        iomem_rdata <= ERR_DATA;
                        per_sel     <= '0;
                        iomem_ready <= 1'b1;
                        state       <= RESP;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
            // A coincident clear loses to a new error, which then owns err_addr
            if (log_err) begin
                err_flag <= 1'b1;
                if (!err_flag || err_clear) err_addr <= log_addr;
            end else if (err_clear) begin
                err_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_iomem_ctrl.sv
// Bench for iomem_ctrl: directed scenarios plus randomized transactions checked
// against a transaction-level model of latency, read data and the error log.
module tb_iomem_ctrl;

    localparam int          NSL  = 4;
    localparam int          TMO  = 8;
    localparam logic [7:0]  BASE = 8'h03;
    localparam logic [31:0] ERR  = 32'hDEAD_BEEF;

    logic             clk;
    logic             reset;
    logic             iomem_valid;
    logic             iomem_ready;
    logic [3:0]       iomem_wstrb;
    logic [31:0]      iomem_addr;
    logic [31:0]      iomem_wdata;
    logic [31:0]      iomem_rdata;
    logic [NSL-1:0]   per_sel;
    logic [3:0]       per_wstrb;
    logic [23:0]      per_addr;
    logic [31:0]      per_wdata;
    logic [NSL-1:0]   per_ready;
    logic [32*NSL-1:0] per_rdata;
    logic             err_flag;
    logic [31:0]      err_addr;
    logic             err_clear;

    iomem_ctrl #(
        .BASE_PAGE(BASE),
        .NUM_SLOTS(NSL),
        .TIMEOUT(TMO),
        .ERR_DATA(ERR)
    ) dut (
        .clk(clk), .reset(reset),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
        .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
        .per_sel(per_sel), .per_wstrb(per_wstrb), .per_addr(per_addr),
        .per_wdata(per_wdata), .per_ready(per_ready), .per_rdata(per_rdata),
        .err_flag(err_flag), .err_addr(err_addr), .err_clear(err_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic        m_flag = 1'b0;
    logic [31:0] m_addr = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic log_err(input logic [31:0] a, input logic clr);
        if (!m_flag || clr) m_addr = a;
        m_flag = 1'b1;
    endtask

    task automatic noise();
        per_ready = NSL'($urandom);
        for (int i = 0; i < NSL; i++) per_rdata[32*i +: 32] = $urandom;
    endtask

    // mode 0: no clear, 1: clear on first idle cycle, 2: random clears
    task automatic gap(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("gap_sel", 32'(per_sel), 32'd0);
            check("gap_ready", 32'(iomem_ready), 32'd0);
            check("gap_err_flag", 32'(err_flag), 32'(m_flag));
            check("gap_err_addr", err_addr, m_addr);
            noise();
            iomem_valid = 1'b0;
            err_clear = (mode == 1 && i == 0) || (mode == 2 && $urandom_range(0, 5) == 0);
            if (err_clear) m_flag = 1'b0;
        end
    endtask

    // d: select cycle on which the slot answers (0 = never)
    task automatic txn(input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata,
                       input int d, input logic [31:0] rd, input logic clr);
        int          slot;
        bit          mapped;
        int          exp_rdy;
        logic [31:0] exp_rd;
        logic [NSL-1:0] oh;
        slot   = int'(addr[31:24]) - int'(BASE);
        mapped = (slot >= 0) && (slot < NSL);
        oh     = mapped ? (NSL'(1) << slot) : '0;
        @(negedge clk);
        check("start_sel", 32'(per_sel), 32'd0);
        check("start_ready", 32'(iomem_ready), 32'd0);
        check("start_err_flag", 32'(err_flag), 32'(m_flag));
        check("start_err_addr", err_addr, m_addr);
        noise();
        iomem_valid = 1'b1;
        iomem_addr  = addr;
        iomem_wstrb = wstrb;
        iomem_wdata = wdata;
        err_clear   = clr;
        if (!mapped) begin
            log_err(addr, clr);
            exp_rdy = 1;
            exp_rd  = ERR;
        end else begin
            if (clr) m_flag = 1'b0;
            if (d >= 1 && d <= TMO) begin
                exp_rdy = d + 1;
                exp_rd  = rd;
            end else begin
                exp_rdy = TMO + 1;
                exp_rd  = ERR;
                log_err(addr, 1'b0);
            end
        end
        for (int c = 1; c <= exp_rdy; c++) begin
            @(negedge clk);
            err_clear = 1'b0;
            check("sel", 32'(per_sel), (mapped && c < exp_rdy) ? 32'(oh) : 32'd0);
            check("ready", 32'(iomem_ready), (c == exp_rdy) ? 32'd1 : 32'd0);
            if (c == 1) begin
                check("per_addr", 32'(per_addr), 32'(addr[23:0]));
                check("per_wstrb", 32'(per_wstrb), 32'(wstrb));
                check("per_wdata", per_wdata, wdata);
            end
            noise();
            if (mapped && c < exp_rdy) begin
                per_ready[slot] = (c == d);
                if (c == d) per_rdata[32*slot +: 32] = rd;
                iomem_valid = ($urandom_range(0, 3) != 0);
            end
            if (c == exp_rdy) begin
                check("rdata", iomem_rdata, exp_rd);
                check("err_flag", 32'(err_flag), 32'(m_flag));
                check("err_addr", err_addr, m_addr);
                iomem_valid = 1'b0;
                if (mapped) per_ready[slot] = 1'b1;
            end
        end
    endtask

    initial begin
        logic [7:0] page;
        reset       = 1'b1;
        iomem_valid = 1'b0;
        iomem_wstrb = '0;
        iomem_addr  = '0;
        iomem_wdata = '0;
        per_ready   = '0;
        per_rdata   = '0;
        err_clear   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(iomem_ready), 32'd0);
        check("rst_rdata", iomem_rdata, 32'd0);
        check("rst_sel", 32'(per_sel), 32'd0);
        check("rst_wstrb", 32'(per_wstrb), 32'd0);
        check("rst_addr", 32'(per_addr), 32'd0);
        check("rst_wdata", per_wdata, 32'd0);
        check("rst_err_flag", 32'(err_flag), 32'd0);
        check("rst_err_addr", err_addr, 32'd0);
        reset = 1'b0;

        txn(32'h0400_0010, 4'b0000, 32'h0, 3, 32'h1234_5678, 1'b0);
        txn(32'h0300_0000, 4'b0011, 32'hAABB_CCDD, 1, 32'h5555_AAAA, 1'b0);
        txn(32'h0500_0020, 4'b0000, 32'h0, 0, 32'h0, 1'b0);
        gap(2, 1);
        txn(32'h0900_0000, 4'b0000, 32'h0, 0, 32'h0, 1'b0);
        txn(32'h0A00_0004, 4'b0000, 32'h0, 0, 32'h0, 1'b0);
        txn(32'h0B00_0008, 4'b1111, 32'h1, 0, 32'h0, 1'b1);

        // Reset in the middle of a slot-0 access
        @(negedge clk);
        err_clear   = 1'b0;
        per_ready   = '0;
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0300_0040;
        iomem_wstrb = 4'b0000;
        repeat (3) begin
            @(negedge clk);
            check("pre_rst_sel", 32'(per_sel), 32'd1);
        end
        reset       = 1'b1;
        iomem_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_sel", 32'(per_sel), 32'd0);
        check("mid_rst_ready", 32'(iomem_ready), 32'd0);
        check("mid_rst_rdata", iomem_rdata, 32'd0);
        check("mid_rst_addr", 32'(per_addr), 32'd0);
        check("mid_rst_err_flag", 32'(err_flag), 32'd0);
        check("mid_rst_err_addr", err_addr, 32'd0);
        reset  = 1'b0;
        m_flag = 1'b0;
        m_addr = '0;
        gap(2, 0);

        for (int n = 0; n < 150; n++) begin
            page = ($urandom_range(0, 9) < 7) ? BASE + 8'($urandom_range(0, NSL - 1)) : 8'($urandom);
            txn({page, 24'($urandom)}, $urandom_range(0, 1) != 0 ? 4'($urandom) : 4'b0000,
                $urandom, $urandom_range(0, 10), $urandom, $urandom_range(0, 7) == 0);
            gap($urandom_range(0, 2), 2);
        end
        gap(1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
